// File: rtl/wash_prog_seq.sv
`default_nettype none
// ============================================================================
//  Module      : wash_prog_seq
//  Description : Washer program sequencer. Runs the selected stages in
//                ascending order, each lasting water level x stage
//                multiplier time units, with pause, abort, skip and repeat
//                of one stage. Reports active stage and remaining times.
//  Revision    : 1.0  initial release
// ============================================================================
module wash_prog_seq #(
  parameter int unsigned            NSTG      = 5,
  parameter int unsigned            WBIT      = 6,
  parameter int unsigned            MBIT      = 4,
  parameter logic [NSTG*MBIT-1:0]   STG_MUL   = {4'd2, 4'd3, 4'd2, 4'd1, 4'd1},
  parameter int unsigned            RPT_IDX   = 4,
  parameter int unsigned            CBIT      = 8,
  parameter int unsigned            TICK_CMAX = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [NSTG-1:0] mask_i,
  input  logic [WBIT-1:0] u_wat_i,
  input  logic [1:0]      rep_i,
  input  logic            pau_i,
  input  logic            clr_i,
  input  logic            skip_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [NSTG-1:0] stg_oh_o,
  output logic [CBIT-1:0] t_stg_o,
  output logic [CBIT-1:0] t_rem_o
);

  localparam int unsigned c_durw = WBIT + MBIT;
  // wide enough that the program-time sum never wraps before saturation
  localparam int unsigned c_accw = CBIT + WBIT + MBIT + 2;
  localparam int unsigned c_pbit = (TICK_CMAX > 1) ? $clog2(TICK_CMAX) : 1;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NSTG-1:0]   mask_q, mask_d;
  logic [WBIT-1:0]   wat_q, wat_d;
  logic [1:0]        rep_q, rep_d;
  logic [c_pbit-1:0] presc_q, presc_d;
  logic [CBIT-1:0]   t_stg_q, t_stg_d;
  logic [CBIT-1:0]   t_rem_q, t_rem_d;
  logic              done_q, done_d;

  logic              w_tick;
  logic              w_retire;
  logic [NSTG-1:0]   w_left;
  logic [c_accw-1:0] w_acc;
  int                w_lo;

  // stage duration in time units, full precision
  function automatic logic [c_durw-1:0] dur_f(input logic [WBIT-1:0] wat, input int idx);
    logic [MBIT-1:0] mul;
    mul = STG_MUL[idx*MBIT +: MBIT];
    return c_durw'(wat) * c_durw'(mul);
  endfunction

  // clamp a wide time value to the output counter range
  function automatic logic [CBIT-1:0] sat_f(input logic [c_accw-1:0] v);
    if (v > c_accw'({CBIT{1'b1}})) return {CBIT{1'b1}};
    return v[CBIT-1:0];
  endfunction

  // index of the lowest set bit (0 when none set)
  function automatic int low_idx(input logic [NSTG-1:0] m);
    int r;
    r = 0;
    for (int i = int'(NSTG) - 1; i >= 0; i--) begin
      if (m[i]) r = i;
    end
    return r;
  endfunction

  // next-state logic: program launch, timing, stage retirement and remaining-time sum
  always_comb begin
    state_d  = state_q;
    mask_d   = mask_q;
    wat_d    = wat_q;
    rep_d    = rep_q;
    presc_d  = presc_q;
    t_stg_d  = t_stg_q;
    done_d   = 1'b0;
    w_tick   = 1'b0;
    w_retire = 1'b0;
    w_left   = mask_q & ~(mask_q & (~mask_q + 1'b1));
    w_acc    = '0;
    w_lo     = 0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !clr_i && (mask_i != '0)) begin
          state_d = S_RUN;
          mask_d  = mask_i;
          wat_d   = u_wat_i;
          rep_d   = rep_i;
          presc_d = '0;
          t_stg_d = sat_f(c_accw'(dur_f(u_wat_i, low_idx(mask_i))));
        end
      end
      S_RUN: begin
        if (clr_i) begin
          state_d = S_IDLE;
          mask_d  = '0;
          wat_d   = '0;
          rep_d   = '0;
          presc_d = '0;
          t_stg_d = '0;
        end else if (!pau_i) begin
          w_tick   = (presc_q == c_pbit'(TICK_CMAX - 1));
          // a zero-length stage retires on its first running cycle
          w_retire = skip_i || (t_stg_q == '0) || (w_tick && (t_stg_q == CBIT'(1)));
          presc_d  = w_tick ? '0 : presc_q + c_pbit'(1);
          if (w_retire) begin
            presc_d = '0;
            if ((low_idx(mask_q) == int'(RPT_IDX)) && (rep_q != 2'd0)) begin
              rep_d   = rep_q - 2'd1;
              t_stg_d = sat_f(c_accw'(dur_f(wat_q, int'(RPT_IDX))));
            end else if (w_left == '0) begin
              state_d = S_IDLE;
              mask_d  = '0;
              wat_d   = '0;
              rep_d   = '0;
              t_stg_d = '0;
              done_d  = 1'b1;
            end else begin
              mask_d  = w_left;
              t_stg_d = sat_f(c_accw'(dur_f(wat_q, low_idx(w_left))));
            end
          end else if (w_tick) begin
            t_stg_d = t_stg_q - CBIT'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // remaining program time is derived from next-state values so it
    // lands in the same cycle as the stage counter it includes
    w_lo  = low_idx(mask_d);
    w_acc = c_accw'(t_stg_d);
    for (int j = 0; j < int'(NSTG); j++) begin
      if (mask_d[j] && (j != w_lo)) w_acc = w_acc + c_accw'(dur_f(wat_d, j));
    end
    if (mask_d[RPT_IDX]) begin
      w_acc = w_acc + c_accw'(rep_d) * c_accw'(dur_f(wat_d, int'(RPT_IDX)));
    end
    t_rem_d = sat_f(w_acc);
  end

  // state and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      wat_q   <= '0;
      rep_q   <= '0;
      presc_q <= '0;
      t_stg_q <= '0;
      t_rem_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      wat_q   <= wat_d;
      rep_q   <= rep_d;
      presc_q <= presc_d;
      t_stg_q <= t_stg_d;
      t_rem_q <= t_rem_d;
      done_q  <= done_d;
    end
  end

  assign busy_o   = (state_q == S_RUN);
  assign done_o   = done_q;
  assign stg_oh_o = mask_q & (~mask_q + 1'b1);
  assign t_stg_o  = t_stg_q;
  assign t_rem_o  = t_rem_q;

endmodule
`default_nettype wire

// File: tb/tb_wash_prog_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wash_prog_seq
//  Description : Directed bench for wash_prog_seq with a run-queue model
//                compared every cycle plus literal spot checks.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wash_prog_seq;

  localparam int TCK = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_i, pau_i, clr_i, skip_i;
  logic [4:0] mask_i;
  logic [5:0] u_wat_i;
  logic [1:0] rep_i;
  logic       busy_o, done_o;
  logic [4:0] stg_oh_o;
  logic [7:0] t_stg_o, t_rem_o;

  int n_tests = 0;
  int n_fail  = 0;

  wash_prog_seq #(.TICK_CMAX(TCK)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .mask_i(mask_i),
    .u_wat_i(u_wat_i), .rep_i(rep_i), .pau_i(pau_i), .clr_i(clr_i),
    .skip_i(skip_i), .busy_o(busy_o), .done_o(done_o), .stg_oh_o(stg_oh_o),
    .t_stg_o(t_stg_o), .t_rem_o(t_rem_o)
  );

  always #5 clk = ~clk;

  // ---------------- model: program expanded into a queue of stage runs
  int mul[5] = '{1, 1, 2, 3, 2};
  int m_q[$];
  bit m_busy, m_done;
  int m_cur, m_t, m_ph, m_wat;

  function automatic int satc(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  function automatic int mdur(input int i);
    return m_wat * mul[i];
  endfunction

  task automatic mreset();
    m_q.delete();
    m_busy = 0; m_done = 0; m_cur = 0; m_t = 0; m_ph = 0; m_wat = 0;
  endtask

  task automatic mstep();
    bit ret;
    m_done = 0;
    if (!m_busy) begin
      if (start_i && !clr_i && mask_i != 0) begin
        m_wat = int'(u_wat_i);
        m_q.delete();
        for (int i = 0; i < 5; i++) begin
          if (mask_i[i]) begin
            m_q.push_back(i);
            if (i == 4) for (int k = 0; k < int'(rep_i); k++) m_q.push_back(i);
          end
        end
        m_cur = m_q.pop_front();
        m_t = satc(mdur(m_cur)); m_ph = 0; m_busy = 1;
      end
    end else if (clr_i) begin
      m_busy = 0; m_q.delete(); m_t = 0; m_ph = 0;
    end else if (!pau_i) begin
      ret = skip_i || (m_t == 0);
      if (m_ph == TCK - 1) begin
        m_ph = 0;
        if (m_t == 1) ret = 1;
        else if (!ret) m_t = m_t - 1;
      end else m_ph = m_ph + 1;
      if (ret) begin
        m_ph = 0;
        if (m_q.size() == 0) begin
          m_busy = 0; m_done = 1; m_t = 0;
        end else begin
          m_cur = m_q.pop_front();
          m_t = satc(mdur(m_cur));
        end
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic mcompare();
    int sum;
    sum = m_t;
    foreach (m_q[k]) sum += mdur(m_q[k]);
    chk("model.busy",   32'(busy_o),   32'(m_busy));
    chk("model.done",   32'(done_o),   32'(m_done));
    chk("model.stg_oh", 32'(stg_oh_o), m_busy ? 32'(1 << m_cur) : 32'd0);
    chk("model.t_stg",  32'(t_stg_o),  m_busy ? 32'(m_t) : 32'd0);
    chk("model.t_rem",  32'(t_rem_o),  m_busy ? 32'(satc(sum)) : 32'd0);
  endtask

  // advance the model on every clock edge and compare just after it
  always @(posedge clk) begin
    if (!rst_n) mreset();
    else mstep();
    #1;
    mcompare();
  end

  // ---------------- directed stimulus
  task automatic wn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [4:0] m, input int w, input int r);
    mask_i = m; u_wat_i = 6'(w); rep_i = 2'(r); start_i = 1'b1;
    wn(1);
    start_i = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start_i = 0; pau_i = 0; clr_i = 0; skip_i = 0;
    mask_i = 0; u_wat_i = 0; rep_i = 0;
    mreset();
    wn(2);
    rst_n = 1'b1;
    wn(1);
    chk("rst.busy", 32'(busy_o), 0);
    chk("rst.stg_oh", 32'(stg_oh_o), 0);
    chk("rst.t_rem", 32'(t_rem_o), 0);

    // 1: two stages, nominal run
    go(5'b00101, 2, 0);
    chk("t1.stg0", 32'(stg_oh_o), 1);
    chk("t1.t_stg0", 32'(t_stg_o), 2);
    chk("t1.t_rem0", 32'(t_rem_o), 6);
    wn(7);
    chk("t1.t_rem7", 32'(t_rem_o), 5);
    wn(1);
    chk("t1.stg8", 32'(stg_oh_o), 4);
    chk("t1.t_stg8", 32'(t_stg_o), 4);
    wn(15);
    chk("t1.busy23", 32'(busy_o), 1);
    wn(1);
    chk("t1.done24", 32'(done_o), 1);
    chk("t1.busy24", 32'(busy_o), 0);
    wn(2);

    // 2: repeat stage run three times
    go(5'b10000, 1, 2);
    chk("t2.t_rem0", 32'(t_rem_o), 6);
    wn(8);
    chk("t2.t_rem8", 32'(t_rem_o), 4);
    chk("t2.t_stg8", 32'(t_stg_o), 2);
    wn(16);
    chk("t2.done24", 32'(done_o), 1);
    wn(2);

    // 3: pause for ten cycles, skip ignored while paused
    go(5'b00101, 2, 0);
    wn(2); pau_i = 1'b1;
    wn(2); skip_i = 1'b1;
    wn(1); skip_i = 1'b0;
    chk("t3.stg_pau", 32'(stg_oh_o), 1);
    chk("t3.t_stg_pau", 32'(t_stg_o), 2);
    wn(7); pau_i = 1'b0;
    wn(21);
    chk("t3.done33", 32'(done_o), 0);
    wn(1);
    chk("t3.done34", 32'(done_o), 1);
    wn(2);

    // 4: skip first stage; start while running is ignored
    go(5'b00101, 2, 0);
    wn(2); skip_i = 1'b1;
    wn(1); skip_i = 1'b0;
    chk("t4.stg", 32'(stg_oh_o), 4);
    chk("t4.t_stg", 32'(t_stg_o), 4);
    chk("t4.t_rem", 32'(t_rem_o), 4);
    wn(2); start_i = 1'b1; mask_i = 5'b11111;
    wn(1); start_i = 1'b0;
    wn(13);
    chk("t4.done", 32'(done_o), 1);
    wn(2);

    // 5: abort while running, while paused, and together with start
    go(5'b00101, 2, 0);
    wn(4); clr_i = 1'b1;
    wn(1); clr_i = 1'b0;
    chk("t5a.busy", 32'(busy_o), 0);
    chk("t5a.t_rem", 32'(t_rem_o), 0);
    go(5'b00101, 2, 0);
    wn(1); pau_i = 1'b1;
    wn(2); clr_i = 1'b1;
    wn(1); clr_i = 1'b0; pau_i = 1'b0;
    chk("t5b.busy", 32'(busy_o), 0);
    chk("t5b.t_stg", 32'(t_stg_o), 0);
    clr_i = 1'b1;
    go(5'b00101, 2, 0);
    clr_i = 1'b0;
    chk("t5c.busy", 32'(busy_o), 0);
    wn(3);

    // 6: zero water level, then empty mask
    go(5'b11111, 0, 0);
    chk("t6.stg0", 32'(stg_oh_o), 1);
    chk("t6.t_rem0", 32'(t_rem_o), 0);
    wn(4);
    chk("t6.stg4", 32'(stg_oh_o), 16);
    wn(1);
    chk("t6.done", 32'(done_o), 1);
    wn(1);
    go(5'b00000, 2, 0);
    chk("t6.nomask", 32'(busy_o), 0);
    wn(3);

    // saturation of the program total
    go(5'b11000, 63, 1);
    chk("sat.stg", 32'(stg_oh_o), 8);
    chk("sat.t_stg", 32'(t_stg_o), 189);
    chk("sat.t_rem", 32'(t_rem_o), 255);
    clr_i = 1'b1; wn(1); clr_i = 1'b0;
    go(5'b10000, 63, 0);
    chk("sat.t_rem1", 32'(t_rem_o), 126);
    clr_i = 1'b1; wn(1); clr_i = 1'b0;
    wn(2);

    // asynchronous reset mid-run
    go(5'b00101, 2, 0);
    wn(3);
    rst_n = 1'b0;
    #1;
    chk("arst.busy", 32'(busy_o), 0);
    chk("arst.t_stg", 32'(t_stg_o), 0);
    wn(1);
    rst_n = 1'b1;
    wn(3);
    chk("arst.idle", 32'(busy_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
